econ_input_assembler: RTL and testbench



---
 rtl/econ_input_assembler_if.sv | 27 ++
 rtl/econ_input_assembler.sv | 121 ++++++++++++
 tb/tb_econ_input_assembler.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/econ_input_assembler_if.sv
// Bus bundle for econ_input_assembler: narrow word stream in, wide rsc-style frame out.
// slave modport is the assembler view; master modport is the producer/consumer view.
interface econ_input_assembler_if #(
  parameter int unsigned N_WORDS = 48,
  parameter int unsigned WORD_W  = 18
);
  localparam int unsigned FRAME_W = N_WORDS * WORD_W;

  logic [WORD_W-1:0]  in_dat;
  logic               in_vld;
  logic               in_rdy;
  logic               in_last;
  logic [FRAME_W-1:0] out_rsc_dat;
  logic               out_rsc_vld;
  logic               out_rsc_rdy;
  logic               frame_err;

  modport slave (
    input  in_dat, in_vld, in_last, out_rsc_rdy,
    output in_rdy, out_rsc_dat, out_rsc_vld, frame_err
  );

  modport master (
    output in_dat, in_vld, in_last, out_rsc_rdy,
    input  in_rdy, out_rsc_dat, out_rsc_vld, frame_err
  );
endinterface

// File: rtl/econ_input_assembler.sv
// econ_input_assembler: packs N_WORDS input words into one frame for the econV0
// encoder input port (input_48_rsc_dat/vld/rdy). Word 0 lands in the LSBs.
// The next frame assembles while the previous one is held; only the final word
// of a frame can stall. Optional saturating error counter: ECON_ASM_ERRCNT_EN.
module econ_input_assembler #(
  parameter int unsigned N_WORDS = 48,
  parameter int unsigned WORD_W  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  econ_input_assembler_if.slave bus
`ifdef ECON_ASM_ERRCNT_EN
  ,
  input  logic                  err_clr,
  output logic [7:0]            err_count
`endif
);

  localparam int unsigned FRAME_W = N_WORDS * WORD_W;
  localparam int unsigned CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] asm_q, asm_d;
  logic [FRAME_W-1:0] dat_q, dat_d;
  logic               vld_q, vld_d;
  logic               err_q, err_d;
  logic               in_rdy_c;
  logic               accept_c;

  // Ready unless the last word would overwrite a frame that is still held.
  always_comb begin
    in_rdy_c = !rst && ((cnt_q != LAST_IDX) || !vld_q || bus.out_rsc_rdy);
    accept_c = bus.in_vld && in_rdy_c;
  end

  // Next-state: word placement, frame hand-off, framing-error detection.
  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    dat_d = dat_q;
    vld_d = vld_q;
    err_d = 1'b0;

    if (vld_q && bus.out_rsc_rdy) begin
      vld_d = 1'b0;
    end

    if (accept_c) begin
      if (cnt_q == LAST_IDX) begin
        // Completed frame: assembly bits plus the incoming top word.
        dat_d = asm_q;
        dat_d[FRAME_W-1 -: WORD_W] = bus.in_dat;
        vld_d = 1'b1;
        cnt_d = '0;
        asm_d = '0;
        err_d = !bus.in_last;
      end else if (bus.in_last) begin
        // Early last: drop the partial frame.
        cnt_d = '0;
        asm_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        for (int k = 0; k < int'(N_WORDS) - 1; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            asm_d[k*WORD_W +: WORD_W] = bus.in_dat;
          end
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      asm_q <= '0;
      dat_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      dat_q <= dat_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  assign bus.in_rdy      = in_rdy_c;
  assign bus.out_rsc_dat = dat_q;
  assign bus.out_rsc_vld = vld_q;
  assign bus.frame_err   = err_q;

`ifdef ECON_ASM_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of frame_err pulses; clear wins over increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = 8'd0;
    end else if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_econ_input_assembler.sv
// Self-checking bench for econ_input_assembler. A word-list model rebuilds
// expected frames from accepted words; tasks compare against it and against
// frames they construct themselves. Build with ECON_ASM_ERRCNT_EN for err_count.
module tb_econ_input_assembler;
  localparam int unsigned NW = 48;
  localparam int unsigned WW = 18;
  localparam int unsigned FW = NW * WW;

  logic clk;
  logic rst;
  econ_input_assembler_if #(.N_WORDS(NW), .WORD_W(WW)) bus();
`ifdef ECON_ASM_ERRCNT_EN
  logic       err_clr;
  logic [7:0] err_count;
`endif

  econ_input_assembler #(.N_WORDS(NW), .WORD_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ECON_ASM_ERRCNT_EN
    ,
    .err_clr   (err_clr),
    .err_count (err_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [FW-1:0] rx[$];
  logic [FW-1:0] exp_q[$];
  int            rx_cyc[$];
  logic [WW-1:0] cur[$];
  int            cyc = 0;
  int            err_seen = 0;
  int            exp_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: collect accepted words, emit a frame every NW words, flag framing errors.
  always @(negedge clk) begin
    logic [FW-1:0] f;
    cyc++;
    if (bus.frame_err) err_seen++;
    if (rst) begin
      cur.delete();
    end else begin
      if (bus.out_rsc_vld && bus.out_rsc_rdy) begin
        rx.push_back(bus.out_rsc_dat);
        rx_cyc.push_back(cyc);
      end
      if (bus.in_vld && bus.in_rdy) begin
        cur.push_back(bus.in_dat);
        if (cur.size() == NW) begin
          f = '0;
          for (int k = 0; k < int'(NW); k++) f[k*WW +: WW] = cur[k];
          exp_q.push_back(f);
          if (!bus.in_last) exp_err++;
          cur.delete();
        end else if (bus.in_last) begin
          exp_err++;
          cur.delete();
        end
      end
    end
  end

  function automatic logic [FW-1:0] pack(input logic [WW-1:0] w[NW]);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < int'(NW); k++) f[k*WW +: WW] = w[k];
    return f;
  endfunction

  task automatic rand_words(output logic [WW-1:0] w[NW]);
    for (int k = 0; k < int'(NW); k++) w[k] = WW'($urandom);
  endtask

  task automatic idle(input int n);
    bus.in_vld = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_queues();
    rx.delete();
    exp_q.delete();
    rx_cyc.delete();
  endtask

  // Offers one word and returns after the edge where it transferred.
  task automatic send_word(input logic [WW-1:0] d, input logic last, output int waited);
    logic ok;
    bus.in_vld  = 1'b1;
    bus.in_dat  = d;
    bus.in_last = last;
    waited = 0;
    forever begin
      @(negedge clk);
      ok = bus.in_rdy;
      @(posedge clk);
      #2;
      if (ok) break;
      waited++;
      if (waited > 300) begin
        checks++;
        failures++;
        $display("FAIL send_word_timeout: waited %0d cycles, required acceptance", waited);
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [WW-1:0] w[NW], input logic last_ok, output int waits);
    int wt;
    waits = 0;
    for (int k = 0; k < int'(NW); k++) begin
      send_word(w[k], (k == int'(NW) - 1) ? last_ok : 1'b0, wt);
      waits += wt;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_vld = 1'b1;
    bus.in_dat = '1;
    bus.in_last = 1'b0;
    bus.out_rsc_rdy = 1'b1;
`ifdef ECON_ASM_ERRCNT_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (bus.out_rsc_vld !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b expected 0", bus.out_rsc_vld); end
    checks++; if (bus.out_rsc_dat !== '0) begin failures++; $display("FAIL reset_dat: got %0h expected 0", bus.out_rsc_dat[127:0]); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus.frame_err); end
    checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy: got %b expected 0", bus.in_rdy); end
`ifdef ECON_ASM_ERRCNT_EN
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
`endif
    @(posedge clk); #2;
    bus.in_vld = 1'b0;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    int wt;
    int bad;
    int e0;
    clear_queues();
    e0 = err_seen;
    bus.out_rsc_rdy = 1'b1;
    for (int k = 0; k < int'(NW) - 1; k++) send_word(WW'(k + 1), 1'b0, wt);
    bus.in_vld = 1'b1;
    bus.in_dat = WW'(NW);
    bus.in_last = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL single_last_rdy: got %b expected 1", bus.in_rdy); end
    checks++; if (bus.out_rsc_vld !== 1'b0) begin failures++; $display("FAIL single_vld_early: got %b expected 0", bus.out_rsc_vld); end
    @(posedge clk); #2;
    bus.in_vld = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_rsc_vld !== 1'b1) begin failures++; $display("FAIL single_latency: got vld %b expected 1", bus.out_rsc_vld); end
    bad = 0;
    for (int k = 0; k < int'(NW); k++) if (bus.out_rsc_dat[k*WW +: WW] !== WW'(k + 1)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL single_packing: got %0d bad words expected 0", bad); end
    @(negedge clk);
    checks++; if (bus.out_rsc_vld !== 1'b0) begin failures++; $display("FAIL single_drain: got vld %b expected 0", bus.out_rsc_vld); end
    checks++; if (err_seen != e0) begin failures++; $display("FAIL single_no_err: got %0d pulses expected 0", err_seen - e0); end
    checks++; if (rx.size() != 1 || exp_q.size() != 1 || rx[0] !== exp_q[0]) begin failures++; $display("FAIL single_model: got %0d frames expected 1 matching", rx.size()); end
    idle(2);
  endtask

  task automatic test_back_pressure();
    logic [WW-1:0] wa[NW];
    logic [WW-1:0] wb[NW];
    logic [FW-1:0] fa, fb;
    int wt, waits, hold_bad, rdy_bad;
    clear_queues();
    rand_words(wa);
    rand_words(wb);
    fa = pack(wa);
    fb = pack(wb);
    bus.out_rsc_rdy = 1'b1;
    send_frame(wa, 1'b1, wt);
    bus.out_rsc_rdy = 1'b0;
    waits = 0;
    hold_bad = 0;
    for (int k = 0; k < int'(NW) - 1; k++) begin
      send_word(wb[k], 1'b0, wt);
      waits += wt;
      if (bus.out_rsc_vld !== 1'b1 || bus.out_rsc_dat !== fa) hold_bad++;
    end
    checks++; if (waits != 0) begin failures++; $display("FAIL bp_early_stall: got %0d stall cycles expected 0", waits); end
    bus.in_vld = 1'b1;
    bus.in_dat = wb[NW-1];
    bus.in_last = 1'b1;
    rdy_bad = 0;
    repeat (13) begin
      @(negedge clk);
      if (bus.in_rdy !== 1'b0) rdy_bad++;
      if (bus.out_rsc_vld !== 1'b1 || bus.out_rsc_dat !== fa) hold_bad++;
      @(posedge clk); #2;
    end
    checks++; if (rdy_bad != 0) begin failures++; $display("FAIL bp_last_stall: got %0d ready cycles expected 0", rdy_bad); end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_bad); end
    bus.out_rsc_rdy = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL bp_release_rdy: got %b expected 1", bus.in_rdy); end
    @(posedge clk); #2;
    bus.in_vld = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_rsc_vld !== 1'b1 || bus.out_rsc_dat !== fb) begin failures++; $display("FAIL bp_b_next: got %0h expected %0h", bus.out_rsc_dat[127:0], fb[127:0]); end
    idle(3);
    checks++; if (rx.size() != 2 || rx[0] !== fa || rx[1] !== fb) begin failures++; $display("FAIL bp_sequence: got %0d frames expected 2 (A,B)", rx.size()); end
    checks++; if (exp_q.size() != 2 || exp_q[0] !== fa || exp_q[1] !== fb) begin failures++; $display("FAIL bp_model: got %0d model frames expected 2", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] w[3][NW];
    int wt, waits, bad;
    clear_queues();
    bus.out_rsc_rdy = 1'b1;
    waits = 0;
    for (int f = 0; f < 3; f++) rand_words(w[f]);
    for (int f = 0; f < 3; f++) begin
      send_frame(w[f], 1'b1, wt);
      waits += wt;
    end
    idle(3);
    checks++; if (waits != 0) begin failures++; $display("FAIL b2b_in_rdy: got %0d stall cycles expected 0", waits); end
    checks++; if (rx.size() != 3) begin failures++; $display("FAIL b2b_count: got %0d frames expected 3", rx.size()); end
    bad = 0;
    for (int f = 0; f < 3; f++) if (f >= rx.size() || rx[f] !== pack(w[f])) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_contents: got %0d bad frames expected 0", bad); end
    bad = 0;
    for (int f = 1; f < 3; f++) if (f >= rx_cyc.size() || rx_cyc[f] - rx_cyc[f-1] != int'(NW)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_period: got %0d bad intervals expected 0", bad); end
  endtask

  task automatic test_early_last();
    logic [WW-1:0] w[NW];
    int wt, e0;
    clear_queues();
    e0 = err_seen;
    bus.out_rsc_rdy = 1'b1;
    for (int k = 0; k < 10; k++) send_word(WW'($urandom), 1'b0, wt);
    send_word(WW'($urandom), 1'b1, wt);
    bus.in_vld = 1'b0;
    @(negedge clk);
    checks++; if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL early_err_pulse: got %b expected 1", bus.frame_err); end
    @(negedge clk);
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL early_err_width: got %b expected 0", bus.frame_err); end
    @(posedge clk); #2;
    checks++; if (rx.size() != 0) begin failures++; $display("FAIL early_no_frame: got %0d frames expected 0", rx.size()); end
    rand_words(w);
    send_frame(w, 1'b1, wt);
    idle(3);
    checks++; if (rx.size() != 1 || rx[0] !== pack(w)) begin failures++; $display("FAIL early_recovery: got %0d frames expected 1 matching", rx.size()); end
    checks++; if (err_seen - e0 != 1) begin failures++; $display("FAIL early_err_count: got %0d pulses expected 1", err_seen - e0); end
  endtask

  task automatic test_missing_last();
    logic [WW-1:0] w[NW];
    int wt, e0;
    clear_queues();
    bus.out_rsc_rdy = 1'b1;
`ifdef ECON_ASM_ERRCNT_EN
    err_clr = 1'b1;
    @(posedge clk); #2;
    err_clr = 1'b0;
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL errcnt_initial: got %0d expected 0", err_count); end
`endif
    e0 = err_seen;
    rand_words(w);
    send_frame(w, 1'b0, wt);
    bus.in_vld = 1'b0;
    @(negedge clk);
    checks++; if (bus.frame_err !== 1'b1 || bus.out_rsc_vld !== 1'b1) begin failures++; $display("FAIL missing_err_pulse: got err %b vld %b expected 1 1", bus.frame_err, bus.out_rsc_vld); end
    @(negedge clk);
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL missing_err_width: got %b expected 0", bus.frame_err); end
    idle(3);
    checks++; if (rx.size() != 1 || rx[0] !== pack(w)) begin failures++; $display("FAIL missing_frame: got %0d frames expected 1 matching", rx.size()); end
    checks++; if (err_seen - e0 != 1) begin failures++; $display("FAIL missing_err_count: got %0d pulses expected 1", err_seen - e0); end
`ifdef ECON_ASM_ERRCNT_EN
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL errcnt_incr: got %0d expected 1", err_count); end
    err_clr = 1'b1;
    @(posedge clk); #2;
    err_clr = 1'b0;
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL errcnt_clear: got %0d expected 0", err_count); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [WW-1:0] w[NW];
    int wt, bad;
    clear_queues();
    bus.out_rsc_rdy = 1'b1;
    for (int k = 0; k <= 20; k++) send_word(WW'($urandom), 1'b0, wt);
    bus.in_vld = 1'b1;
    rst = 1'b1;
    #1;
    bad = 0;
    if (bus.in_rdy !== 1'b0 || bus.out_rsc_vld !== 1'b0) bad++;
    repeat (2) begin
      @(negedge clk);
      if (bus.in_rdy !== 1'b0) bad++;
      @(posedge clk); #2;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rst_mid_rdy: got %0d ready samples expected 0", bad); end
    bus.in_vld = 1'b0;
    rst = 1'b0;
    idle(1);
    rand_words(w);
    send_frame(w, 1'b1, wt);
    idle(3);
    checks++; if (rx.size() != 1 || rx[0] !== pack(w)) begin failures++; $display("FAIL rst_mid_frame: got %0d frames expected 1 matching", rx.size()); end
    checks++; if (exp_q.size() != 1 || exp_q[0] !== pack(w)) begin failures++; $display("FAIL rst_mid_model: got %0d model frames expected 1", exp_q.size()); end

    clear_queues();
    bus.out_rsc_rdy = 1'b0;
    rand_words(w);
    send_frame(w, 1'b1, wt);
    idle(2);
    checks++; if (bus.out_rsc_vld !== 1'b1 || bus.out_rsc_dat !== pack(w)) begin failures++; $display("FAIL rst_held_before: got vld %b expected 1", bus.out_rsc_vld); end
    rst = 1'b1;
    #1;
    checks++; if (bus.out_rsc_vld !== 1'b0 || bus.in_rdy !== 1'b0) begin failures++; $display("FAIL rst_held_drop: got vld %b rdy %b expected 0 0", bus.out_rsc_vld, bus.in_rdy); end
    idle(2);
    rst = 1'b0;
    exp_q.delete();
    bus.out_rsc_rdy = 1'b1;
    idle(1);
    checks++; if (rx.size() != 0) begin failures++; $display("FAIL rst_held_lost: got %0d frames expected 0", rx.size()); end
    rand_words(w);
    send_frame(w, 1'b1, wt);
    idle(3);
    checks++; if (rx.size() != 1 || rx[0] !== pack(w)) begin failures++; $display("FAIL rst_held_recovery: got %0d frames expected 1 matching", rx.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_pressure();
    test_back_to_back();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    checks++; if (err_seen != exp_err) begin failures++; $display("FAIL total_frame_err: got %0d expected %0d", err_seen, exp_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
